// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-seg scan decoder: synchronizes seg_n/dig_n, waits for stable digits, assembles frames; dp capture under SEG_SCAN_DP_EN.
// Latency: 2 sync + STABLE_CYCLES + 1 cycles to frame_valid; no backpressure, frame_valid/err are single-cycle pulses.
module seg_scan_decoder #(
  parameter int         STABLE_CYCLES = 16,
  parameter logic [7:0] DIGIT_MASK    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_n,
  input  logic [7:0]  dig_n,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic        frame_valid,
  output logic        err
);

  typedef enum logic [1:0] {WAIT_BLANK, WAIT_DIG, SETTLE, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
`ifdef SEG_SCAN_DP_EN
  localparam logic [7:0] SEG_USED = 8'hFF;
`else
  localparam logic [7:0] SEG_USED = 8'h7F;
`endif

  state_t      state;
  logic [7:0]  seg_m, s_seg, dig_m, s_dig, prev_seg, prev_dig;
  logic [7:0]  seen, cnt;
  logic [31:0] shadow;
  logic [2:0]  cur, idx;
  logic [3:0]  n_lit, code;
  logic        publish, one_hot, multi, blank, changed, capture, illegal;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F:   seg_decode = 4'h0;
      7'h06:   seg_decode = 4'h1;
      7'h5B:   seg_decode = 4'h2;
      7'h4F:   seg_decode = 4'h3;
      7'h66:   seg_decode = 4'h4;
      7'h6D:   seg_decode = 4'h5;
      7'h7D:   seg_decode = 4'h6;
      7'h07:   seg_decode = 4'h7;
      7'h7F:   seg_decode = 4'h8;
      7'h6F:   seg_decode = 4'h9;
      7'h00:   seg_decode = 4'hF;
      default: seg_decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    n_lit = '0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      if (!s_dig[i]) begin
        n_lit = n_lit + 4'd1;
        idx   = i[2:0];
      end
    end
    one_hot = (n_lit == 4'd1);
    multi   = (n_lit > 4'd1);
    blank   = (n_lit == 4'd0);
    // dp only counts towards stability when it is actually captured
    changed = (((s_seg ^ prev_seg) & SEG_USED) != 8'h00) || (s_dig != prev_dig);
    capture = (state == SETTLE) && one_hot && !changed && (cnt == CNT_LAST);
    code    = seg_decode(~s_seg[6:0]);
    illegal = (code == 4'hE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_m       <= 8'hFF;
      s_seg       <= 8'hFF;
      dig_m       <= 8'hFF;
      s_dig       <= 8'hFF;
      prev_seg    <= 8'hFF;
      prev_dig    <= 8'hFF;
      state       <= WAIT_BLANK;
      cnt         <= '0;
      cur         <= '0;
      seen        <= '0;
      shadow      <= 32'hFFFF_FFFF;
      digits      <= 32'hFFFF_FFFF;
      publish     <= 1'b0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      seg_m       <= seg_n;
      s_seg       <= seg_m;
      dig_m       <= dig_n;
      s_dig       <= dig_m;
      prev_seg    <= s_seg;
      prev_dig    <= s_dig;
      frame_valid <= 1'b0;
      err         <= 1'b0;

      if (publish) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        seen        <= '0;
        publish     <= 1'b0;
      end

      case (state)
        WAIT_BLANK: if (blank) state <= WAIT_DIG;
        WAIT_DIG: begin
          if (multi) begin
            err   <= 1'b1;
            state <= WAIT_BLANK;
          end else if (one_hot) begin
            cur   <= idx;
            cnt   <= 8'd1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (multi) begin
            err   <= 1'b1;
            state <= WAIT_BLANK;
          end else if (blank) begin
            state <= WAIT_DIG;
          end else if (changed) begin
            cur <= idx;
            cnt <= 8'd1;
          end else if (capture) begin
            // seen bit written after the publish clear so it survives the same edge
            shadow[{cur, 2'b00} +: 4] <= code;
            seen[cur] <= 1'b1;
            cnt       <= cnt + 8'd1;
            if (illegal) err <= 1'b1;
            if (((seen | (8'h01 << cur)) & DIGIT_MASK) == DIGIT_MASK) publish <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (multi) begin
            err   <= 1'b1;
            state <= WAIT_BLANK;
          end else if (blank) begin
            state <= WAIT_DIG;
          end else if (idx != cur) begin
            cur   <= idx;
            cnt   <= 8'd1;
            state <= SETTLE;
          end
        end
        default: state <= WAIT_BLANK;
      endcase
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [7:0] dp_shadow, dp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_shadow <= '0;
      dp_q      <= '0;
    end else begin
      if (capture) dp_shadow[cur] <= ~s_seg[7];
      if (publish) dp_q <= dp_shadow;
    end
  end

  assign dp = dp_q;
`else
  assign dp = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: full-mask instance (a) and DIGIT_MASK=8'h3F instance (b).
module tb_seg_scan_decoder;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  p;
  } frame_t;

`ifdef SEG_SCAN_DP_EN
  localparam logic [7:0] DP_EXP = 8'h04;
`else
  localparam logic [7:0] DP_EXP = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg_n_a, dig_n_a, seg_n_b, dig_n_b;
  logic [31:0] digits_a, digits_b;
  logic [7:0]  dp_a, dp_b;
  logic        fv_a, fv_b, err_a, err_b;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, drive_cyc = 0, last_fv_cyc = 0;
  int frames_a = 0, frames_b = 0, errs_a = 0, errs_b = 0;
  frame_t exp_a[$], exp_b[$];
  frame_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_decoder dut_a (
    .clk(clk), .reset(reset), .seg_n(seg_n_a), .dig_n(dig_n_a),
    .digits(digits_a), .dp(dp_a), .frame_valid(fv_a), .err(err_a)
  );

  seg_scan_decoder #(.STABLE_CYCLES(16), .DIGIT_MASK(8'h3F)) dut_b (
    .clk(clk), .reset(reset), .seg_n(seg_n_b), .dig_n(dig_n_b),
    .digits(digits_b), .dp(dp_b), .frame_valid(fv_b), .err(err_b)
  );

  // Scoreboard: every published frame must match the oldest expected entry
  always @(negedge clk) begin
    if (err_a === 1'b1) errs_a++;
    if (err_b === 1'b1) errs_b++;
    if (fv_a === 1'b1) begin
      frames_a++;
      last_fv_cyc = cyc;
      n_checks++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_unexpected: frame digits=%h dp=%h, no frame expected", digits_a, dp_a);
      end else begin
        ea = exp_a.pop_front();
        if (digits_a !== ea.d || dp_a !== ea.p) begin
          n_fail++;
          $display("FAIL sb_a_frame: digits=%h dp=%h, expected digits=%h dp=%h", digits_a, dp_a, ea.d, ea.p);
        end
      end
    end
    if (fv_b === 1'b1) begin
      frames_b++;
      n_checks++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_unexpected: frame digits=%h dp=%h, no frame expected", digits_b, dp_b);
      end else begin
        eb = exp_b.pop_front();
        if (digits_b !== eb.d || dp_b !== eb.p) begin
          n_fail++;
          $display("FAIL sb_b_frame: digits=%h dp=%h, expected digits=%h dp=%h", digits_b, dp_b, eb.d, eb.p);
        end
      end
    end
  end

  // Encoder for the stimulus; E encodes an illegal pattern, F a dark digit
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hE: seg7 = 7'h49;
      default: seg7 = 7'h00;
    endcase
  endfunction

  task automatic show(input bit b, input int k, input logic [6:0] pat, input bit dpb,
                      input int lit, input int blank);
    logic [7:0] one;
    one = 8'h01;
    @(posedge clk); #1;
    if (b) begin dig_n_b = ~(one << k); seg_n_b = ~{dpb, pat}; end
    else   begin dig_n_a = ~(one << k); seg_n_a = ~{dpb, pat}; end
    drive_cyc = cyc;
    repeat (lit) @(posedge clk);
    #1;
    if (b) begin dig_n_b = 8'hFF; seg_n_b = 8'hFF; end
    else   begin dig_n_a = 8'hFF; seg_n_a = 8'hFF; end
    repeat (blank) @(posedge clk);
  endtask

  task automatic scan(input bit b, input logic [31:0] val, input logic [7:0] dps,
                      input int hi, input int lo);
    for (int k = hi; k >= lo; k--) show(b, k, seg7(val[4*k +: 4]), dps[k], 125, 10);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    seg_n_a = 8'hFF; dig_n_a = 8'hFF; seg_n_b = 8'hFF; dig_n_b = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (digits_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_digits: got %h, expected ffffffff", digits_a); end
    n_checks++; if (dp_a !== 8'h00) begin n_fail++; $display("FAIL reset_dp: got %h, expected 00", dp_a); end
    n_checks++; if (fv_a !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b, expected 0", fv_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err_a); end
    n_checks++; if (digits_b !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_digits_b: got %h, expected ffffffff", digits_b); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic_frame;
    int f0, e0;
    f0 = frames_a; e0 = errs_a;
    exp_a.push_back('{32'h1234_5678, 8'h00});
    scan(1'b0, 32'h1234_5678, 8'h00, 7, 0);
    n_checks++; if (frames_a - f0 !== 1) begin n_fail++; $display("FAIL basic_frames: got %0d, expected 1", frames_a - f0); end
    n_checks++; if (errs_a - e0 !== 0) begin n_fail++; $display("FAIL basic_err: got %0d, expected 0", errs_a - e0); end
    n_checks++; if (last_fv_cyc - drive_cyc !== 19) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 19", last_fv_cyc - drive_cyc); end
  endtask

  task automatic test_bad_segments;
    int f0, e0;
    f0 = frames_a; e0 = errs_a;
    exp_a.push_back('{32'h12E4_F678, 8'h00});
    scan(1'b0, 32'h12E4_F678, 8'h00, 7, 0);
    n_checks++; if (frames_a - f0 !== 1) begin n_fail++; $display("FAIL badseg_frames: got %0d, expected 1", frames_a - f0); end
    n_checks++; if (errs_a - e0 !== 1) begin n_fail++; $display("FAIL badseg_err: got %0d, expected 1", errs_a - e0); end
  endtask

  task automatic test_multi_hot;
    int f0, e0;
    f0 = frames_a; e0 = errs_a;
    @(posedge clk); #1;
    dig_n_a = 8'hF3; seg_n_a = ~{1'b0, seg7(4'h1)};
    repeat (20) @(posedge clk);
    #1; dig_n_a = 8'hFF; seg_n_a = 8'hFF;
    repeat (10) @(posedge clk);
    n_checks++; if (errs_a - e0 !== 1) begin n_fail++; $display("FAIL multihot_err: got %0d, expected 1", errs_a - e0); end
    n_checks++; if (frames_a - f0 !== 0) begin n_fail++; $display("FAIL multihot_frames: got %0d, expected 0", frames_a - f0); end
    exp_a.push_back('{32'h8765_4321, 8'h00});
    scan(1'b0, 32'h8765_4321, 8'h00, 7, 0);
    n_checks++; if (frames_a - f0 !== 1) begin n_fail++; $display("FAIL multihot_recover: got %0d, expected 1", frames_a - f0); end
  endtask

  task automatic test_glitch;
    int f0, e0;
    f0 = frames_a; e0 = errs_a;
    for (int k = 7; k >= 0; k--) begin
      for (int c = 0; c < 125; c++) begin
        @(posedge clk); #1;
        dig_n_a = ~(8'h01 << k);
        seg_n_a = (c % 10 == 9) ? ~{1'b0, seg7(4'h8)} : ~{1'b0, seg7(4'h3)};
      end
      @(posedge clk); #1;
      dig_n_a = 8'hFF; seg_n_a = 8'hFF;
      repeat (10) @(posedge clk);
    end
    n_checks++; if (frames_a - f0 !== 0) begin n_fail++; $display("FAIL glitch_frames: got %0d, expected 0", frames_a - f0); end
    n_checks++; if (errs_a - e0 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d, expected 0", errs_a - e0); end
  endtask

  task automatic test_digit_mask;
    int f0;
    f0 = frames_b;
    exp_b.push_back('{32'hFF12_3456, 8'h00});
    scan(1'b1, 32'hFF12_3456, 8'h00, 5, 0);
    n_checks++; if (frames_b - f0 !== 1) begin n_fail++; $display("FAIL mask_first: got %0d, expected 1", frames_b - f0); end
    show(1'b1, 7, seg7(4'h9), 1'b0, 125, 10);
    exp_b.push_back('{32'h9F65_4321, 8'h00});
    scan(1'b1, 32'h0065_4321, 8'h00, 5, 0);
    n_checks++; if (frames_b - f0 !== 2) begin n_fail++; $display("FAIL mask_second: got %0d, expected 2", frames_b - f0); end
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    scan(1'b0, 32'h1122_3344, 8'h00, 7, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (digits_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midreset_digits: got %h, expected ffffffff", digits_a); end
    n_checks++; if (dp_a !== 8'h00) begin n_fail++; $display("FAIL midreset_dp: got %h, expected 00", dp_a); end
    reset = 1'b0;
    f0 = frames_a;
    scan(1'b0, 32'h2468_1357, DP_EXP, 3, 0);
    n_checks++; if (frames_a - f0 !== 0) begin n_fail++; $display("FAIL midreset_partial: got %0d frames, expected 0", frames_a - f0); end
    exp_a.push_back('{32'h2468_1357, DP_EXP});
    scan(1'b0, 32'h2468_1357, DP_EXP, 7, 4);
    n_checks++; if (frames_a - f0 !== 1) begin n_fail++; $display("FAIL midreset_full: got %0d frames, expected 1", frames_a - f0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_segments();
    test_multi_hot();
    test_glitch();
    test_digit_mask();
    test_reset_mid_frame();
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (exp_a.size() !== 0) begin n_fail++; $display("FAIL sb_a_drain: %0d frames outstanding, expected 0", exp_a.size()); end
    n_checks++; if (exp_b.size() !== 0) begin n_fail++; $display("FAIL sb_b_drain: %0d frames outstanding, expected 0", exp_b.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
